coffee_vend_ctrl: RTL and testbench

//  Top-level vending sequencer for the coffee maker. Reads the coin counter's running total (units of 100),

---
 rtl/coffee_vend_ctrl_pkg.sv | 13 +
 rtl/coffee_vend_ctrl_phase_timer.sv | 18 +
 rtl/coffee_vend_ctrl.sv | 123 ++++++++++++
 tb/tb_coffee_vend_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/coffee_vend_ctrl_pkg.sv
// coffee_vend_ctrl_pkg: shared state encoding, widths and drink pricing helper
package coffee_vend_ctrl_pkg;
  localparam int CRED_W = 4;
  localparam int TMR_W = 24;
  localparam logic [1:0] DRINK0 = 2'd0;
  localparam logic [1:0] DRINK1 = 2'd1;
  localparam logic [1:0] DRINK2 = 2'd2;
  localparam logic [1:0] DRINK3 = 2'd3;
  typedef enum logic [2:0] {IDLE, CHECK, GRIND, BREW, POUR, CHANGE} state_t;
  function automatic logic [CRED_W-1:0] price_of(input logic [1:0] d, input logic [CRED_W-1:0] p0, p1, p2, p3);
    return d == DRINK0 ? p0 : d == DRINK1 ? p1 : d == DRINK2 ? p2 : d == DRINK3 ? p3 : p0;
  endfunction
endpackage

// File: rtl/coffee_vend_ctrl_phase_timer.sv
// coffee_vend_ctrl_phase_timer: loadable down-counter, done while the last cycle of a phase is running
module coffee_vend_ctrl_phase_timer
  import coffee_vend_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == TMR_W'(1);
endmodule

// File: rtl/coffee_vend_ctrl.sv
// coffee_vend_ctrl: vending sequencer (price check, grind/brew/pour, change); CUP_SENSE_EN enables cup sensing
module coffee_vend_ctrl
  import coffee_vend_ctrl_pkg::*;
#(
  parameter int unsigned PRICE0    = 3,
  parameter int unsigned PRICE1    = 4,
  parameter int unsigned PRICE2    = 5,
  parameter int unsigned PRICE3    = 7,
  parameter int unsigned GRIND_CYC = 5000000,
  parameter int unsigned BREW_CYC  = 20000000,
  parameter int unsigned POUR_CYC  = 10000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CRED_W-1:0] credit,
  input  logic              sel_valid,
  input  logic [1:0]        sel_drink,
  input  logic              cancel,
  input  logic              cup_present,
  output logic              clr_credit,
  output logic              grind_on,
  output logic              brew_on,
  output logic              pour_on,
  output logic              change_vld,
  output logic [CRED_W-1:0] change_amt,
  output logic              err_funds,
  output logic              busy
);
  state_t state;
  logic [CRED_W-1:0] lat_credit, price;
  logic [1:0] lat_drink;
  logic cup_ok, funds_ok, tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
`ifdef CUP_SENSE_EN
  assign cup_ok = cup_present;
`else
  logic unused_cup;
  assign unused_cup = cup_present;
  assign cup_ok = 1'b1;
`endif
  assign price = price_of(lat_drink, CRED_W'(PRICE0), CRED_W'(PRICE1), CRED_W'(PRICE2), CRED_W'(PRICE3));
  assign funds_ok = lat_credit >= price;
  // the single timer is reloaded on the same edge that enters the next phase
  assign tmr_load = (state == CHECK && funds_ok && cup_ok) || ((state == GRIND || state == BREW) && tmr_done);
  assign tmr_val = state == CHECK ? TMR_W'(GRIND_CYC) : state == GRIND ? TMR_W'(BREW_CYC) : TMR_W'(POUR_CYC);
  coffee_vend_ctrl_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lat_credit <= '0;
      lat_drink  <= '0;
      clr_credit <= 1'b0;
      grind_on   <= 1'b0;
      brew_on    <= 1'b0;
      pour_on    <= 1'b0;
      change_vld <= 1'b0;
      change_amt <= '0;
      err_funds  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      clr_credit <= 1'b0;
      change_vld <= 1'b0;
      err_funds  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            lat_credit <= credit;
            lat_drink  <= sel_drink;
            state      <= CHECK;
            busy       <= 1'b1;
          end else if (cancel) begin
            change_amt <= credit;
            change_vld <= 1'b1;
            clr_credit <= 1'b1;
          end
        end
        CHECK: begin
          if (!funds_ok) begin
            err_funds <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (cup_ok) begin
            clr_credit <= 1'b1;
            change_amt <= lat_credit - price;
            grind_on   <= 1'b1;
            state      <= GRIND;
          end else if (cancel) begin
            change_amt <= credit;
            change_vld <= 1'b1;
            clr_credit <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        GRIND: if (tmr_done) begin
          grind_on <= 1'b0;
          brew_on  <= 1'b1;
          state    <= BREW;
        end
        BREW: if (tmr_done) begin
          brew_on <= 1'b0;
          pour_on <= 1'b1;
          state   <= POUR;
        end
        POUR: if (tmr_done || !cup_ok) begin
          pour_on    <= 1'b0;
          change_vld <= 1'b1;
          state      <= CHANGE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// tb_coffee_vend_ctrl: timeline reference model with random stimulus plus directed literal checks
module tb_coffee_vend_ctrl;
  localparam int G = 3, B = 4, P = 2;
  localparam int PR[4] = '{3, 4, 5, 7};
  logic clk = 1'b0, reset_n = 1'b0, sel_valid = 1'b0, cancel = 1'b0, cup_present = 1'b1;
  logic [3:0] credit = '0;
  logic [1:0] sel_drink = '0;
  logic clr_credit, grind_on, brew_on, pour_on, change_vld, err_funds, busy;
  logic [3:0] change_amt;
  int checks = 0, errors = 0;
  bit chk_en = 1'b1;

  coffee_vend_ctrl #(.GRIND_CYC(G), .BREW_CYC(B), .POUR_CYC(P)) dut (
    .clk(clk), .reset_n(reset_n), .credit(credit), .sel_valid(sel_valid), .sel_drink(sel_drink),
    .cancel(cancel), .cup_present(cup_present), .clr_credit(clr_credit), .grind_on(grind_on),
    .brew_on(brew_on), .pour_on(pour_on), .change_vld(change_vld), .change_amt(change_amt),
    .err_funds(err_funds), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a purchase accepted at edge n lays out a fixed timeline of output windows
  int e = 0, n = 0, busy_end = -10;
  bit has_tx = 0, tx_ok = 0;
  logic [3:0] tx_amt, m_amt = '0;
  bit x_clr, x_cv, x_err, x_g, x_b, x_p, x_busy;
  always @(posedge clk) begin
    if (!reset_n) begin
      e = 0; has_tx = 0; busy_end = -10; m_amt = '0;
    end else begin
      e++;
      x_clr = 0; x_cv = 0; x_err = 0;
      if (e > busy_end + 1) begin
        if (sel_valid) begin
          has_tx = 1; n = e;
          tx_ok = int'(credit) >= PR[sel_drink];
          tx_amt = credit - 4'(PR[sel_drink]);
          busy_end = tx_ok ? n + G + B + P + 1 : n;
        end else if (cancel) begin
          m_amt = credit; x_cv = 1; x_clr = 1;
        end
      end
      if (has_tx && e == n + 1) begin
        if (tx_ok) begin x_clr = 1; m_amt = tx_amt; end
        else x_err = 1;
      end
      x_g = has_tx && tx_ok && e >= n + 1 && e <= n + G;
      x_b = has_tx && tx_ok && e >= n + G + 1 && e <= n + G + B;
      x_p = has_tx && tx_ok && e >= n + G + B + 1 && e <= n + G + B + P;
      if (has_tx && tx_ok && e == n + G + B + P + 1) x_cv = 1;
      x_busy = e <= busy_end;
    end
    #1;
    if (reset_n && chk_en) begin
      chk("clr_credit", clr_credit, x_clr);
      chk("grind_on", grind_on, x_g);
      chk("brew_on", brew_on, x_b);
      chk("pour_on", pour_on, x_p);
      chk("change_vld", change_vld, x_cv);
      chk("change_amt", change_amt, m_amt);
      chk("err_funds", err_funds, x_err);
      chk("busy", busy, x_busy);
    end
  end

  int ng, nb, np, nc, nv, ne;
  logic [3:0] amt;
  task automatic run_purchase(input logic [3:0] cr, input logic [1:0] dr, input bit intf);
    bit done_intf = 0;
    ng = 0; nb = 0; np = 0; nc = 0; nv = 0; ne = 0; amt = 'x;
    @(negedge clk); credit = cr; sel_drink = dr; sel_valid = 1;
    @(negedge clk); sel_valid = 0;
    for (int i = 0; i < 20; i++) begin
      ng += int'(grind_on); nb += int'(brew_on); np += int'(pour_on);
      nc += int'(clr_credit); ne += int'(err_funds);
      if (change_vld) begin nv++; amt = change_amt; end
      sel_valid = 0; cancel = 0;
      if (intf && brew_on && !done_intf) begin
        sel_valid = 1; cancel = 1; sel_drink = 0; credit = 15; done_intf = 1;
      end
      @(negedge clk);
    end
    sel_valid = 0; cancel = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_amt", change_amt, 0);
    chk("rst_valves", {grind_on, brew_on, pour_on}, 0);
    chk("rst_pulses", {clr_credit, change_vld, err_funds}, 0);
    reset_n = 1;
    run_purchase(4'd5, 2'd1, 0);
    chk("t1_grind", ng, 3); chk("t1_brew", nb, 4); chk("t1_pour", np, 2);
    chk("t1_clr", nc, 1); chk("t1_cv", nv, 1); chk("t1_amt", amt, 1); chk("t1_err", ne, 0);
    run_purchase(4'd2, 2'd3, 0);
    chk("t2_err", ne, 1); chk("t2_clr", nc, 0); chk("t2_valves", ng + nb + np, 0);
    chk("t2_cv", nv, 0); chk("t2_busy", busy, 0);
    @(negedge clk); credit = 6; cancel = 1;
    @(negedge clk); cancel = 0;
    chk("t3_cv", change_vld, 1); chk("t3_clr", clr_credit, 1); chk("t3_amt", change_amt, 6);
    run_purchase(4'd9, 2'd2, 1);
    chk("t4_grind", ng, 3); chk("t4_brew", nb, 4); chk("t4_pour", np, 2);
    chk("t4_clr", nc, 1); chk("t4_cv", nv, 1); chk("t4_amt", amt, 4);
    run_purchase(4'd7, 2'd3, 0);
    chk("t_zero_cv", nv, 1); chk("t_zero_amt", amt, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sel_valid = $urandom_range(0, 7) == 0;
      cancel = $urandom_range(0, 9) == 0;
      sel_drink = 2'($urandom_range(0, 3));
      credit = 4'($urandom_range(0, 15));
`ifndef CUP_SENSE_EN
      cup_present = 1'($urandom_range(0, 1));
`endif
    end
    @(negedge clk); sel_valid = 0; cancel = 0; cup_present = 1;
    repeat (14) @(negedge clk);
    credit = 5; sel_drink = 1; sel_valid = 1;
    @(negedge clk); sel_valid = 0;
    for (int k = 0; k < 30 && !brew_on; k++) @(negedge clk);
    chk("t5_wait_brew", brew_on, 1);
    #2 reset_n = 0;
    #1;
    chk("t5_brew", brew_on, 0); chk("t5_busy", busy, 0); chk("t5_amt", change_amt, 0);
    chk("t5_valves", {grind_on, pour_on}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
`ifdef CUP_SENSE_EN
    chk_en = 0;
    @(negedge clk); cup_present = 0; credit = 5; sel_drink = 0; sel_valid = 1;
    @(negedge clk); sel_valid = 0;
    repeat (4) @(negedge clk);
    chk("t6_hold_busy", busy, 1); chk("t6_hold_grind", grind_on, 0); chk("t6_hold_err", err_funds, 0);
    cup_present = 1;
    @(negedge clk);
    chk("t6_grind", grind_on, 1);
    for (int k = 0; k < 30 && !pour_on; k++) @(negedge clk);
    chk("t6_wait_pour", pour_on, 1);
    cup_present = 0;
    @(negedge clk);
    chk("t6_pour_off", pour_on, 0); chk("t6_cv", change_vld, 1);
    cup_present = 1;
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
